pipelined_carry_select_adder: RTL and testbench

//   Parametrised carry-select adder: WIDTH-bit A+B+cin split into BLOCK-bit segments.

---
 rtl/pcsa_pkg.sv | 22 ++
 rtl/pipelined_carry_select_adder_segment.sv | 41 ++++
 rtl/pipelined_carry_select_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcsa_pkg.sv
// Shared constants, helper function and segment result type for the
// pipelined carry-select adder.
package pcsa_pkg;

  localparam int PCSA_DEF_WIDTH = 16;
  localparam int PCSA_DEF_BLOCK = 4;

  // Number of segments; a non-positive block yields zero so the caller's
  // parameter check can report the problem instead of dividing by zero.
  function automatic int nblk(input int width, input int block);
    return (block < 1) ? 0 : width / block;
  endfunction

  // Precomputed per-segment result at the default segment width.
  typedef struct packed {
    logic [PCSA_DEF_BLOCK-1:0] sum0;
    logic [PCSA_DEF_BLOCK-1:0] sum1;
    logic                      c0;
    logic                      c1;
  } seg_res_t;

endpackage

// File: rtl/pipelined_carry_select_adder_segment.sv
// csa_segment: combinational dual ripple adder over one BLOCK-bit segment,
// producing the sum/carry for both possible carry-ins.
module csa_segment
  import pcsa_pkg::*;
#(
  parameter int BLOCK = PCSA_DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] sum0,
  output logic [BLOCK-1:0] sum1,
  output logic             c0,
  output logic             c1
);

  logic [BLOCK:0] k0;
  logic [BLOCK:0] k1;

  // Two ripple chains, one seeded with carry 0 and one with carry 1.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional logic, so no path can leave it unassigned and infer a latch.
    k0   = '0;
    k1   = '0;
    sum0 = '0;
    sum1 = '0;
    // NOTE: blocking assignments here because each bit's carry must be
    // visible to the next loop iteration within the same evaluation.
    k0[0] = 1'b0;
    k1[0] = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      sum0[i]  = a[i] ^ b[i] ^ k0[i];
      k0[i+1]  = (a[i] & b[i]) | (k0[i] & (a[i] ^ b[i]));
      sum1[i]  = a[i] ^ b[i] ^ k1[i];
      k1[i+1]  = (a[i] & b[i]) | (k1[i] & (a[i] ^ b[i]));
    end
    c0 = k0[BLOCK];
    c1 = k1[BLOCK];
  end

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder: two-stage carry-select adder with valid/ready
// handshake on both sides. Stage 1 registers the per-segment dual results,
// stage 2 resolves the segment carry chain and registers sum/cout.
// Optional signed overflow output enabled by defining PCSA_OVERFLOW_EN.
module pipelined_carry_select_adder
  import pcsa_pkg::*;
#(
  parameter int WIDTH = PCSA_DEF_WIDTH,
  parameter int BLOCK = PCSA_DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PCSA_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NBLK       = nblk(WIDTH, BLOCK);
  localparam int SAFE_BLOCK = (BLOCK < 1) ? 1 : BLOCK;

  if ((BLOCK < 1) || ((WIDTH % SAFE_BLOCK) != 0)) begin : g_param_check
    $error("pipelined_carry_select_adder: WIDTH (%0d) must be a positive multiple of BLOCK (%0d)",
           WIDTH, BLOCK);
  end

  typedef struct packed {
    logic [BLOCK-1:0] sum0;
    logic [BLOCK-1:0] sum1;
    logic             c0;
    logic             c1;
  } seg_t;

  seg_t             seg_comb [NBLK];
  seg_t             s1_seg   [NBLK];
  logic             s1_valid;
  logic             s1_cin;
`ifdef PCSA_OVERFLOW_EN
  logic             s1_a_msb;
  logic             s1_b_msb;
`endif

  logic             adv1;
  logic             adv2;
  logic             accept;
  logic [NBLK:0]    k;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;

  // Handshake: a stage advances when its downstream slot is empty or draining.
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NBLK; i++) begin : g_seg
    csa_segment #(.BLOCK(BLOCK)) u_seg (
      .a    (a[i*BLOCK +: BLOCK]),
      .b    (b[i*BLOCK +: BLOCK]),
      .sum0 (seg_comb[i].sum0),
      .sum1 (seg_comb[i].sum1),
      .c0   (seg_comb[i].c0),
      .c1   (seg_comb[i].c1)
    );
  end

  // Stage 1: capture precomputed segment results on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the stage-1 data registers are cleared on reset as well as the
      // valid bit, so a reset always leaves the pipeline in a known state.
      s1_valid <= 1'b0;
      s1_cin   <= 1'b0;
      for (int i = 0; i < NBLK; i++) s1_seg[i] <= '0;
`ifdef PCSA_OVERFLOW_EN
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
`endif
    end else if (adv1) begin
      // NOTE: non-blocking assignments for all registered state so every
      // flop samples the pre-edge values regardless of statement order.
      s1_valid <= accept;
      if (accept) begin
        s1_cin <= cin;
        for (int i = 0; i < NBLK; i++) s1_seg[i] <= seg_comb[i];
`ifdef PCSA_OVERFLOW_EN
        s1_a_msb <= a[WIDTH-1];
        s1_b_msb <= b[WIDTH-1];
`endif
      end
    end
  end

  // Carry-select chain: each segment carry picks the next segment's result.
  always_comb begin
    k        = '0;
    sum_next = '0;
    k[0]     = s1_cin;
    for (int i = 0; i < NBLK; i++) begin
      sum_next[i*BLOCK +: BLOCK] = k[i] ? s1_seg[i].sum1 : s1_seg[i].sum0;
      k[i+1]                     = k[i] ? s1_seg[i].c1 : s1_seg[i].c0;
    end
    cout_next = k[NBLK];
  end

  // Stage 2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PCSA_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum      <= sum_next;
        cout     <= cout_next;
`ifdef PCSA_OVERFLOW_EN
        overflow <= (s1_a_msb == s1_b_msb) && (sum_next[WIDTH-1] != s1_a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench for pipelined_carry_select_adder: directed vectors on a
// 16/4 instance plus random streams on 8/2, 32/8 and 12/3 instances.
// Honours PCSA_OVERFLOW_EN when defined.
module tb_pipelined_carry_select_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
`ifdef PCSA_OVERFLOW_EN
  logic        overflow;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
  } op_t;

  op_t         pend [$];
  logic [17:0] expq [$];

  pipelined_carry_select_adder #(.WIDTH(16), .BLOCK(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PCSA_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {overflow, cout, sum}; overflow bit is 0 when absent.
  function automatic logic [17:0] model(input op_t o);
    logic [16:0] s;
    logic        ov;
    s  = {1'b0, o.a} + {1'b0, o.b} + {16'b0, o.cin};
    ov = (o.a[15] == o.b[15]) && (s[15] != o.a[15]);
`ifdef PCSA_OVERFLOW_EN
    return {ov, s};
`else
    return {1'b0, s};
`endif
  endfunction

  function automatic logic [17:0] hc(input logic [17:0] v);
`ifdef PCSA_OVERFLOW_EN
    return v;
`else
    return {1'b0, v[16:0]};
`endif
  endfunction

  function automatic logic [17:0] obs();
`ifdef PCSA_OVERFLOW_EN
    return {overflow, cout, sum};
`else
    return {1'b0, cout, sum};
`endif
  endfunction

  // One clock of traffic: drive head of pend, sample away from the edge,
  // score any consumed output against the in-order expectation queue.
  task automatic step(input logic ordy, output bit in_f, output bit out_f,
                      output logic [17:0] got);
    @(negedge clk);
    if (pend.size() > 0) begin
      in_valid = 1'b1;
      a        = pend[0].a;
      b        = pend[0].b;
      cin      = pend[0].cin;
    end else begin
      in_valid = 1'b0;
    end
    out_ready = ordy;
    #1;
    got   = obs();
    in_f  = in_valid && in_ready;
    out_f = out_valid && out_ready;
    if (out_f) begin
      if (expq.size() == 0) check("spurious_out", 1, 0);
      else check("result", got, expq.pop_front());
    end
    if (in_f) expq.push_back(model(pend.pop_front()));
  endtask

  task automatic push_op(input logic [15:0] oa, input logic [15:0] ob, input logic oc);
    op_t o;
    o.a = oa; o.b = ob; o.cin = oc;
    pend.push_back(o);
  endtask

  task automatic run_one(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                         input logic oc, input logic [17:0] exp);
    bit          in_f, out_f, seen;
    logic [17:0] got;
    seen = 0;
    push_op(oa, ob, oc);
    for (int i = 0; i < 8 && !seen; i++) begin
      step(1'b1, in_f, out_f, got);
      if (out_f) begin
        check(tag, got, hc(exp));
        seen = 1;
      end
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
  endtask

  // Parametric instances running independent random streams.
  for (genvar gi = 0; gi < 3; gi++) begin : g_par
    localparam int PW = (gi == 0) ? 8 : (gi == 1) ? 32 : 12;
    localparam int PB = (gi == 0) ? 2 : (gi == 1) ? 8 : 3;
    logic          prst, piv, pir, pov, por, pcin, pco;
    logic [PW-1:0] pa, pb, psum;
`ifdef PCSA_OVERFLOW_EN
    logic          povf;
`endif
    bit            done = 0;

    pipelined_carry_select_adder #(.WIDTH(PW), .BLOCK(PB)) u_dut (
      .clk       (clk),
      .rst       (prst),
      .in_valid  (piv),
      .in_ready  (pir),
      .a         (pa),
      .b         (pb),
      .cin       (pcin),
      .out_valid (pov),
      .out_ready (por),
      .sum       (psum),
      .cout      (pco)
`ifdef PCSA_OVERFLOW_EN
      ,
      .overflow  (povf)
`endif
    );

    initial begin
      logic [PW+1:0] q [$];
      logic [PW+1:0] got;
      logic [PW:0]   s;
      logic          ov;
      int            sent, cyc;
      bit            taken;
      string         tag;
      tag  = $sformatf("p%0d_%0d_result", PW, PB);
      prst = 1'b1; piv = 1'b0; por = 1'b0; pa = '0; pb = '0; pcin = 1'b0;
      sent = 0; cyc = 0; taken = 0;
      repeat (2) @(negedge clk);
      prst = 1'b0;
      while ((sent < 300 || q.size() > 0 || piv) && cyc < 4000) begin
        @(negedge clk);
        cyc++;
        if (taken) piv = 1'b0;
        taken = 0;
        if (!piv && sent < 300) begin
          pa   = PW'($urandom);
          pb   = PW'($urandom);
          pcin = 1'($urandom_range(0, 1));
          piv  = 1'b1;
        end
        por = 1'($urandom_range(0, 1));
        #1;
`ifdef PCSA_OVERFLOW_EN
        got = {povf, pco, psum};
`else
        got = {1'b0, pco, psum};
`endif
        if (pov && por) begin
          if (q.size() == 0) check({tag, "_spurious"}, 1, 0);
          else check(tag, got, q.pop_front());
        end
        if (piv && pir) begin
          s  = {1'b0, pa} + {1'b0, pb} + {{PW{1'b0}}, pcin};
          ov = (pa[PW-1] == pb[PW-1]) && (s[PW-1] != pa[PW-1]);
`ifndef PCSA_OVERFLOW_EN
          ov = 1'b0;
`endif
          q.push_back({ov, s});
          sent++;
          taken = 1;
        end
      end
      check({tag, "_drained"}, (sent == 300) && (q.size() == 0), 1);
      done = 1;
    end
  end

  initial begin
    bit          in_f, out_f;
    logic [17:0] got;
    int          issued, cyc, fires;
    op_t         o;

    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; out_ready = 1'b1;

    // Reset held three cycles with in_valid asserted.
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // Basic add and latency: valid two cycles after the accept cycle.
    push_op(16'h1234, 16'h4321, 1'b0);
    step(1'b1, in_f, out_f, got);
    check("lat_accept", in_f, 1);
    step(1'b1, in_f, out_f, got);
    check("lat_t1_valid", out_valid, 0);
    step(1'b1, in_f, out_f, got);
    check("lat_t2_valid", out_valid, 1);
    check("basic_sum", got, hc(18'h05555));

    // Full carry propagation and wrap.
    run_one("carry_all", 16'hFFFF, 16'h0000, 1'b1, 18'h10000);
    run_one("carry_3seg", 16'h0FFF, 16'h0001, 1'b0, 18'h01000);
    run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 18'h10000);

    // Signed overflow vectors (sum/cout checked in both builds).
    run_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 18'h28000);
    run_one("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 18'h37FFF);

    // Backpressure: four back-to-back operands with the consumer stalled.
    push_op(16'h0001, 16'h0001, 1'b0);
    push_op(16'h00FF, 16'h0001, 1'b0);
    push_op(16'h8000, 16'h8000, 1'b0);
    push_op(16'hABCD, 16'h1111, 1'b1);
    step(1'b0, in_f, out_f, got);
    check("bp_accept0", in_f, 1);
    step(1'b0, in_f, out_f, got);
    check("bp_accept1", in_f, 1);
    step(1'b0, in_f, out_f, got);
    check("bp_ready_low0", in_f, 0);
    check("bp_hold0", {out_valid, got}, {1'b1, hc(18'h00002)});
    step(1'b0, in_f, out_f, got);
    check("bp_ready_low1", in_f, 0);
    check("bp_hold1", {out_valid, got}, {1'b1, hc(18'h00002)});
    fires = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, in_f, out_f, got);
      if (out_f) fires++;
    end
    check("bp_drain_rate", fires, 4);
    check("bp_drain_empty", (pend.size() == 0) && (expq.size() == 0), 1);

    // Reset mid-stream drops in-flight results.
    push_op(16'h1111, 16'h2222, 1'b0);
    push_op(16'h3333, 16'h4444, 1'b1);
    push_op(16'h5555, 16'h6666, 1'b0);
    step(1'b0, in_f, out_f, got);
    step(1'b0, in_f, out_f, got);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", {cout, sum}, 0);
    rst = 1'b0;
    pend.delete();
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, in_f, out_f, got);
      check("mid_rst_stale", out_valid, 0);
    end

    // Random stream with random backpressure.
    issued = 0; cyc = 0;
    while ((issued < 10000 || pend.size() > 0 || expq.size() > 0) && cyc < 60000) begin
      if (pend.size() == 0 && issued < 10000 && $urandom_range(0, 3) != 0) begin
        o.a   = 16'($urandom);
        o.b   = 16'($urandom);
        o.cin = 1'($urandom_range(0, 1));
        pend.push_back(o);
        issued++;
      end
      step(1'($urandom_range(0, 1)), in_f, out_f, got);
      cyc++;
    end
    check("rand_drained", (issued == 10000) && (pend.size() == 0) && (expq.size() == 0), 1);

    // Wait for the parametric streams, bounded.
    for (int w = 0; w < 20000 && !(g_par[0].done && g_par[1].done && g_par[2].done); w++)
      @(negedge clk);
    check("param_done", g_par[0].done && g_par[1].done && g_par[2].done, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
